// File: rtl/comp_minmax_tracker.sv
// comp_minmax_tracker / comp
//
// comp: unsigned magnitude comparator. It reports a>b, a<b and a==b.
//
// comp_minmax_tracker: scans a framed stream of unsigned samples. For each
// frame it tracks the running max and min, the first index of each, and the
// saturating sample count. When the in_last sample has been accepted it
// presents one registered result word. That word is held until out_ready.
//
// Ports:
//   clk, rst         rising-edge clock, async active-low reset
//   in_valid/ready   sample handshake; in_data, in_last qualify the sample
//   out_valid/ready  result handshake
//   out_max/min      extreme sample values of the frame
//   out_max/min_idx  first-occurrence index of each extreme (0-based)
//   out_count        samples in frame, saturating at 2^CNTWIDTH-1
//   out_sat          frame was longer than 2^CNTWIDTH-1 samples

module comp #(
  parameter int DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 gt,
  output logic                 lt,
  output logic                 eq
);
  assign gt = (a > b);
  assign lt = (a < b);
  assign eq = (a == b);
endmodule

module comp_minmax_tracker #(
  parameter int DATAWIDTH = 32,
  parameter int CNTWIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_max,
  output logic [DATAWIDTH-1:0] out_min,
  output logic [CNTWIDTH-1:0]  out_max_idx,
  output logic [CNTWIDTH-1:0]  out_min_idx,
  output logic [CNTWIDTH-1:0]  out_count,
  output logic                 out_sat
);
  localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                state, state_nxt;
  logic                  rdy_en;
  logic [DATAWIDTH-1:0]  max_r, min_r, max_nxt, min_nxt;
  logic [CNTWIDTH-1:0]   max_idx_r, min_idx_r, cnt_r;
  logic [CNTWIDTH-1:0]   max_idx_nxt, min_idx_nxt, cnt_nxt;
  logic                  sat_r, sat_nxt;
  logic                  accept;
  logic                  max_gt, max_lt, max_eq;
  logic                  min_gt, min_lt, min_eq;
  logic                  max_upd, min_upd;

  comp #(.DATAWIDTH(DATAWIDTH)) u_cmp_max (
    .a(in_data), .b(max_r), .gt(max_gt), .lt(max_lt), .eq(max_eq)
  );
  comp #(.DATAWIDTH(DATAWIDTH)) u_cmp_min (
    .a(in_data), .b(min_r), .gt(min_gt), .lt(min_lt), .eq(min_eq)
  );

  // A tie never moves an index, so the first occurrence is always kept.
  assign max_upd = max_gt && !max_eq && !max_lt;
  assign min_upd = min_lt && !min_eq && !min_gt;

  // rdy_en is held low by reset, so in_ready stays low until the first edge
  // after release.
  assign in_ready  = rdy_en && (state != HOLD);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_nxt   = state;
    max_nxt     = max_r;
    min_nxt     = min_r;
    max_idx_nxt = max_idx_r;
    min_idx_nxt = min_idx_r;
    cnt_nxt     = cnt_r;
    sat_nxt     = sat_r;
    case (state)
      IDLE: begin
        if (accept) begin
          max_nxt     = in_data;
          min_nxt     = in_data;
          max_idx_nxt = '0;
          min_idx_nxt = '0;
          cnt_nxt     = CNTWIDTH'(1);
          sat_nxt     = 1'b0;
          state_nxt   = in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          // Past saturation cnt_r sticks at CNT_MAX, so a late index records
          // CNT_MAX.
          if (max_upd) begin
            max_nxt     = in_data;
            max_idx_nxt = cnt_r;
          end
          if (min_upd) begin
            min_nxt     = in_data;
            min_idx_nxt = cnt_r;
          end
          if (cnt_r == CNT_MAX) sat_nxt = 1'b1;
          else                  cnt_nxt = cnt_r + CNTWIDTH'(1);
          if (in_last) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      rdy_en    <= 1'b0;
      max_r     <= '0;
      min_r     <= '0;
      max_idx_r <= '0;
      min_idx_r <= '0;
      cnt_r     <= '0;
      sat_r     <= 1'b0;
    end else begin
      state     <= state_nxt;
      rdy_en    <= 1'b1;
      max_r     <= max_nxt;
      min_r     <= min_nxt;
      max_idx_r <= max_idx_nxt;
      min_idx_r <= min_idx_nxt;
      cnt_r     <= cnt_nxt;
      sat_r     <= sat_nxt;
    end
  end

  // The result word is captured only on entry to HOLD. It is not a live view
  // of the running registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_max     <= '0;
      out_min     <= '0;
      out_max_idx <= '0;
      out_min_idx <= '0;
      out_count   <= '0;
      out_sat     <= 1'b0;
    end else if (state != HOLD && state_nxt == HOLD) begin
      out_max     <= max_nxt;
      out_min     <= min_nxt;
      out_max_idx <= max_idx_nxt;
      out_min_idx <= min_idx_nxt;
      out_count   <= cnt_nxt;
      out_sat     <= sat_nxt;
    end
  end
endmodule

// File: tb/tb_comp_minmax_tracker.sv
// Bench for comp_minmax_tracker. Two instances share one stimulus stream:
// u0 uses the default CNTWIDTH=16 and u4 uses CNTWIDTH=4, which exercises
// count saturation. A frame-level model keeps the accepted samples and
// derives the expected result word from them.
module tb_comp_minmax_tracker;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        rdy0, vld0, sat0;
  logic [31:0] max0, min0;
  logic [15:0] maxi0, mini0, cnt0;
  logic        rdy4, vld4, sat4;
  logic [31:0] max4, min4;
  logic [3:0]  maxi4, mini4, cnt4;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  comp_minmax_tracker u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_last(in_last), .out_valid(vld0),
    .out_ready(out_ready), .out_max(max0), .out_min(min0),
    .out_max_idx(maxi0), .out_min_idx(mini0), .out_count(cnt0),
    .out_sat(sat0)
  );

  comp_minmax_tracker #(.DATAWIDTH(32), .CNTWIDTH(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4),
    .in_data(in_data), .in_last(in_last), .out_valid(vld4),
    .out_ready(out_ready), .out_max(max4), .out_min(min4),
    .out_max_idx(maxi4), .out_min_idx(mini4), .out_count(cnt4),
    .out_sat(sat4)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level model ----------------
  logic [31:0] q[$];
  bit          m_rdy_en, m_hold;
  logic [31:0] e_max, e_min;
  int          e_maxi[2], e_mini[2], e_cnt[2];
  bit          e_sat[2];

  function automatic void finish_frame();
    int mxi = 0;
    int mni = 0;
    int lim;
    for (int i = 1; i < q.size(); i++) begin
      if (q[i] > q[mxi]) mxi = i;
      if (q[i] < q[mni]) mni = i;
    end
    e_max = q[mxi];
    e_min = q[mni];
    for (int w = 0; w < 2; w++) begin
      lim = (w == 0) ? 65535 : 15;
      e_maxi[w] = (mxi > lim) ? lim : mxi;
      e_mini[w] = (mni > lim) ? lim : mni;
      e_cnt[w]  = (q.size() > lim) ? lim : q.size();
      e_sat[w]  = (q.size() > lim);
    end
  endfunction

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      q.delete();
      m_rdy_en = 1'b0;
      m_hold   = 1'b0;
      e_max = '0;
      e_min = '0;
      for (int w = 0; w < 2; w++) begin
        e_maxi[w] = 0; e_mini[w] = 0; e_cnt[w] = 0; e_sat[w] = 1'b0;
      end
    end else begin
      if (m_hold) begin
        if (out_ready) m_hold = 1'b0;
      end else if (in_valid && m_rdy_en) begin
        q.push_back(in_data);
        if (in_last) begin
          finish_frame();
          m_hold = 1'b1;
          q.delete();
        end
      end
      m_rdy_en = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("u0.in_ready", 64'(rdy0), 64'(m_rdy_en && !m_hold));
      chk("u4.in_ready", 64'(rdy4), 64'(m_rdy_en && !m_hold));
      chk("u0.out_valid", 64'(vld0), 64'(m_hold));
      chk("u4.out_valid", 64'(vld4), 64'(m_hold));
      chk("u0.out_max", 64'(max0), 64'(e_max));
      chk("u4.out_max", 64'(max4), 64'(e_max));
      chk("u0.out_min", 64'(min0), 64'(e_min));
      chk("u4.out_min", 64'(min4), 64'(e_min));
      chk("u0.out_max_idx", 64'(maxi0), 64'(e_maxi[0]));
      chk("u4.out_max_idx", 64'(maxi4), 64'(e_maxi[1]));
      chk("u0.out_min_idx", 64'(mini0), 64'(e_mini[0]));
      chk("u4.out_min_idx", 64'(mini4), 64'(e_mini[1]));
      chk("u0.out_count", 64'(cnt0), 64'(e_cnt[0]));
      chk("u4.out_count", 64'(cnt4), 64'(e_cnt[1]));
      chk("u0.out_sat", 64'(sat0), 64'(e_sat[0]));
      chk("u4.out_sat", 64'(sat4), 64'(e_sat[1]));
    end
  end

  // ---------------- stimulus helpers (enter/leave on negedge) ----------------
  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!rdy0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 64'(n), 64'(0));
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pin(input string tag, input logic [31:0] mx, input int mxi,
                     input logic [31:0] mn, input int mni, input int cnt,
                     input bit sat);
    chk({tag, ".valid"}, 64'(vld0), 64'(1));
    chk({tag, ".max"}, 64'(max0), 64'(mx));
    chk({tag, ".max_idx"}, 64'(maxi0), 64'(mxi));
    chk({tag, ".min"}, 64'(min0), 64'(mn));
    chk({tag, ".min_idx"}, 64'(mini0), 64'(mni));
    chk({tag, ".count"}, 64'(cnt0), 64'(cnt));
    chk({tag, ".sat"}, 64'(sat0), 64'(sat));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int len, gap;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (2) @(negedge clk);
    // Reset state.
    chk("rst.in_ready", 64'(rdy0), 64'(0));
    chk("rst.out_valid", 64'(vld0), 64'(0));
    chk("rst.out_max", 64'(max0), 64'(0));
    chk("rst.out_count", 64'(cnt0), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst.in_ready", 64'(rdy0), 64'(1));

    // 1: 5,9,2,9,2. The result is visible one edge after the last sample.
    out_ready = 1'b1;
    send(32'd5, 1'b0); send(32'd9, 1'b0); send(32'd2, 1'b0);
    send(32'd9, 1'b0); send(32'd2, 1'b1);
    pin("t1", 32'd9, 1, 32'd2, 2, 5, 1'b0);
    @(negedge clk);
    chk("t1.valid_drop", 64'(vld0), 64'(0));

    // 2: single sample.
    send(32'h7, 1'b1);
    pin("t2", 32'h7, 0, 32'h7, 0, 1, 1'b0);
    @(negedge clk);
    chk("t2.valid_drop", 64'(vld0), 64'(0));

    // 3: unsigned extremes.
    send(32'hFFFF_FFFF, 1'b0); send(32'h0, 1'b0); send(32'h8000_0000, 1'b1);
    pin("t3", 32'hFFFF_FFFF, 0, 32'h0, 1, 3, 1'b0);
    @(negedge clk);

    // 4: HOLD backpressure while the upstream keeps offering a sample.
    out_ready = 1'b0;
    send(32'd1, 1'b0); send(32'd2, 1'b1);
    in_valid = 1'b1; in_data = 32'd99; in_last = 1'b1;
    repeat (10) @(negedge clk);
    chk("t4.in_ready", 64'(rdy0), 64'(0));
    pin("t4.held", 32'd2, 1, 32'd1, 0, 2, 1'b0);
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4.released", 64'(vld0), 64'(0));
    send(32'd4, 1'b0); send(32'd3, 1'b1);
    pin("t4.next", 32'd4, 0, 32'd3, 1, 2, 1'b0);
    @(negedge clk);

    // 5: 17-sample frame; u4 saturates count and the late max index.
    for (int k = 0; k < 17; k++) send(32'(k + 1), (k == 16));
    pin("t5.u0", 32'd17, 16, 32'd1, 0, 17, 1'b0);
    chk("t5.u4.count", 64'(cnt4), 64'(15));
    chk("t5.u4.sat", 64'(sat4), 64'(1));
    chk("t5.u4.max_idx", 64'(maxi4), 64'(15));
    @(negedge clk);
    // Mid-frame reset discards the partial frame.
    send(32'd50, 1'b0); send(32'd60, 1'b0); send(32'd1, 1'b0);
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5.rst.in_ready", 64'(rdy0), 64'(0));
    chk("t5.rst.out_max", 64'(max0), 64'(0));
    chk("t5.rst.out_min", 64'(min4), 64'(0));
    chk("t5.rst.out_count", 64'(cnt4), 64'(0));
    chk("t5.rst.out_sat", 64'(sat4), 64'(0));
    rst = 1'b1;
    @(negedge clk);
    send(32'd8, 1'b0); send(32'd5, 1'b1);
    pin("t5.next", 32'd8, 0, 32'd5, 1, 2, 1'b0);
    @(negedge clk);

    // 6: random frames with input gaps and delayed out_ready.
    for (int f = 0; f < 24; f++) begin
      out_ready = 1'b0;
      len = $urandom_range(1, 64);
      for (int i = 0; i < len; i++) begin
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
        // Small value ranges in some frames force ties.
        send((f % 3 == 0) ? 32'($urandom_range(0, 5)) : $urandom(),
             (i == len - 1));
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
